// File: rtl/adder_pkg.sv
// Shared widths and result type for the byte-wide ripple-carry adder.
package adder_pkg;

  localparam int BYTE_W   = 8;
  localparam int NIBBLE_W = 4;

  // Exact 9-bit add result: {carry, sum}.
  typedef logic [BYTE_W:0] add_result_t;

endpackage

// File: rtl/adder_nibble_rca.sv
// 4-bit ripple-carry stage; each bit is a full adder made of two half-adder cells.
module adder_nibble_rca
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    logic p;
    logic g_xy;
    logic g_pc;

    // First half adder on the operand bits, second on its sum and the incoming carry.
    assign p      = x[i] ^ y[i];
    assign g_xy   = x[i] & y[i];
    assign s[i]   = p ^ c[i];
    assign g_pc   = p & c[i];
    assign c[i+1] = g_xy | g_pc;
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/adder8_registered.sv
// 8-bit ripple-carry adder with carry-in, half-carry and signed-overflow flags,
// optionally followed by a one-cycle output register.
module adder8_registered
  import adder_pkg::*;
#(
  parameter int unsigned REGISTER_OUTPUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carry_in,
  output logic [BYTE_W-1:0] sum,
  output logic              carry_out,
  output logic              half_carry,
  output logic              overflow,
  output logic              out_valid
);

  // Handshake: in_valid qualifies a/b/carry_in for one cycle; out_valid marks a
  // result on sum and flags. There is no ready: every valid input is accepted.

  logic [NIBBLE_W-1:0] sum_lo;
  logic [NIBBLE_W-1:0] sum_hi;
  logic                carry_mid;
  logic                carry_top;
  add_result_t         result_c;
  logic                overflow_c;

  adder_nibble_rca u_nibble_lo (
    .x    (a[NIBBLE_W-1:0]),
    .y    (b[NIBBLE_W-1:0]),
    .cin  (carry_in),
    .s    (sum_lo),
    .cout (carry_mid)
  );

  adder_nibble_rca u_nibble_hi (
    .x    (a[BYTE_W-1:NIBBLE_W]),
    .y    (b[BYTE_W-1:NIBBLE_W]),
    .cin  (carry_mid),
    .s    (sum_hi),
    .cout (carry_top)
  );

  assign result_c   = {carry_top, sum_hi, sum_lo};
  assign overflow_c = (a[BYTE_W-1] == b[BYTE_W-1]) && (result_c[BYTE_W-1] != a[BYTE_W-1]);

  if (REGISTER_OUTPUT != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum        <= '0;
        carry_out  <= 1'b0;
        half_carry <= 1'b0;
        overflow   <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum        <= result_c[BYTE_W-1:0];
          carry_out  <= result_c[BYTE_W];
          half_carry <= carry_mid;
          overflow   <= overflow_c;
        end
      end
    end
  end else begin : g_comb
    // The clock has no role here; reset only gates the valid flag.
    logic unused_clk;
    assign unused_clk = clk;

    assign sum        = result_c[BYTE_W-1:0];
    assign carry_out  = result_c[BYTE_W];
    assign half_carry = carry_mid;
    assign overflow   = overflow_c;
    assign out_valid  = in_valid & rst_n;
  end

endmodule

// File: tb/tb_adder8_registered.sv
// Bench for adder8_registered: registered and combinational builds side by side,
// directed boundary cases plus random vectors checked through an expected queue.
module tb_adder8_registered;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;

  logic [7:0] r_sum, c_sum;
  logic       r_carry, c_carry, r_half, c_half, r_ovf, c_ovf, r_valid, c_valid;

  int checks = 0;
  int errors = 0;

  // Expected entries: {carry_out, half_carry, overflow, sum}
  logic [10:0] exp_q[$];
  logic [10:0] last_res;

  adder8_registered #(.REGISTER_OUTPUT(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .carry_in(carry_in),
    .sum(r_sum), .carry_out(r_carry), .half_carry(r_half), .overflow(r_ovf), .out_valid(r_valid)
  );

  adder8_registered #(.REGISTER_OUTPUT(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .carry_in(carry_in),
    .sum(c_sum), .carry_out(c_carry), .half_carry(c_half), .overflow(c_ovf), .out_valid(c_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] full;
    logic [4:0] lo;
    logic       ovf;
    full = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    lo   = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, ci};
    ovf  = (x[7] == y[7]) && (full[7] != x[7]);
    return {full[8], lo[4], ovf, full[7:0]};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one valid beat per cycle; result due one cycle later on the registered build.
  task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic ci, input logic [10:0] exp);
    logic [10:0] got;
    @(negedge clk);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    carry_in = ci;
    exp_q.push_back(exp);
    #1;
    check({tag, "_comb"}, {c_valid, c_carry, c_half, c_ovf, c_sum}, {1'b1, exp});
    @(posedge clk);
    #1;
    got      = exp_q.pop_front();
    last_res = got;
    check({tag, "_reg"}, {r_valid, r_carry, r_half, r_ovf, r_sum}, {1'b1, got});
  endtask

  // Idle beat: registered result holds, valid drops.
  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'($urandom_range(0, 255));
    b        = 8'($urandom_range(0, 255));
    carry_in = 1'($urandom_range(0, 1));
    #1;
    check({tag, "_comb_valid"}, {11'd0, c_valid}, 12'd0);
    @(posedge clk);
    #1;
    check({tag, "_reg"}, {r_valid, r_carry, r_half, r_ovf, r_sum}, {1'b0, last_res});
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] rx, ry;
    logic       rc;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    carry_in = 1'b0;
    last_res = '0;

    #3;
    check("reset_state", {r_valid, r_carry, r_half, r_ovf, r_sum}, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream: outputs clear without a clock edge.
    step("pre_reset", 8'h55, 8'h22, 1'b0, {3'b000, 8'h77});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {r_valid, r_carry, r_half, r_ovf, r_sum}, 12'h000);
    check("async_reset_comb_valid", {11'd0, c_valid}, 12'd0);
    @(posedge clk);
    #1;
    check("reset_held", {r_valid, r_carry, r_half, r_ovf, r_sum}, 12'h000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    last_res = '0;
    idle("post_reset_idle");
    step("post_reset", 8'h55, 8'h01, 1'b0, {3'b000, 8'h56});

    // Power-of-two sweep, back-to-back.
    p = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step($sformatf("pow2_%0d", i), p, p, 1'b0, model(p, p, 1'b0));
      p = p << 1;
    end

    // Carries and boundaries: {carry, half, ovf, sum}
    step("ff_ff_c0",  8'hFF, 8'hFF, 1'b0, {3'b110, 8'hFE});
    step("ff_ff_c1",  8'hFF, 8'hFF, 1'b1, {3'b110, 8'hFF});
    step("0f_01",     8'h0F, 8'h01, 1'b0, {3'b010, 8'h10});
    step("aa_55_c1",  8'hAA, 8'h55, 1'b1, {3'b110, 8'h00});
    step("ff_01_wrap", 8'hFF, 8'h01, 1'b0, {3'b110, 8'h00});
    step("00_00_c1",  8'h00, 8'h00, 1'b1, {3'b000, 8'h01});
    step("80_80",     8'h80, 8'h80, 1'b0, {3'b101, 8'h00});
    step("7f_01_ovf", 8'h7F, 8'h01, 1'b0, {3'b011, 8'h80});
    step("f0_0f",     8'hF0, 8'h0F, 1'b0, {3'b000, 8'hFF});

    // Hold
    step("12_34", 8'h12, 8'h34, 1'b0, {3'b000, 8'h46});
    idle("hold_1");
    idle("hold_2");

    // Random vectors with occasional idle beats.
    for (int i = 0; i < 2000; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) idle($sformatf("rand_idle_%0d", i));
      else step($sformatf("rand_%0d", i), rx, ry, rc, model(rx, ry, rc));
    end

    check("queue_empty", 12'(exp_q.size()), 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
